// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation selects and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    FuncAdd = 3'b000,
    FuncSub = 3'b001,
    FuncAnd = 3'b010,
    FuncOr  = 3'b011,
    FuncXor = 3'b100,
    FuncShl = 3'b101,
    FuncShr = 3'b110,
    FuncMul = 3'b111
  } alu_func_e;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: one multiplier bit consumed per step, WIDTH steps per product.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               finished_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     sum;

  // Upper half accumulates; multiplier sits in the lower half and shifts out bit by bit.
  always_comb begin
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
      cnt_d   = '0;
    end else if (step_i) begin
      prod_d = {sum, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  // High on the step that completes the product.
  assign finished_o = step_i && (cnt_q == CntW'(WIDTH - 1));
  assign product_o  = prod_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: latches an operation on start, executes, then publishes result/flags with done.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             carryIn,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             zero,
  output logic             negetive,
  output logic             busy,
  output logic             done
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               ci_q, ci_d;
  alu_func_e          func_q, func_d, func_in;
  logic [WIDTH-1:0]   pend_res_q, pend_res_d;
  logic               pend_co_q, pend_co_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               co_q, co_d, zero_q, zero_d, neg_q, neg_d, done_q, done_d;
  logic [WIDTH-1:0]   alu_res, fin_res;
  logic               alu_co, fin_co;
  logic [WIDTH:0]     sum_w;
  logic               is_mul, mul_load, mul_step, mul_fin;
  logic [2*WIDTH-1:0] mul_prod;

  // Without the multiplier, the MUL encoding degrades to ADD at latch time.
  assign func_in  = (!MUL_EN && (func == FuncMul)) ? FuncAdd : alu_func_e'(func);
  assign is_mul   = (func_q == FuncMul);
  assign mul_load = (state_q == StIdle) && start && (func_in == FuncMul);
  assign mul_step = (state_q == StExec) && is_mul;

  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (inputA),
    .b_i       (inputB),
    .product_o (mul_prod),
    .finished_o(mul_fin)
  );

  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    sum_w   = '0;
    unique case (func_q)
      FuncAdd, FuncMul: begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, ci_q};
        alu_res = sum_w[WIDTH-1:0];
        alu_co  = sum_w[WIDTH];
      end
      FuncSub: begin
        sum_w   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, ci_q};
        alu_res = sum_w[WIDTH-1:0];
        alu_co  = sum_w[WIDTH];
      end
      FuncAnd: alu_res = a_q & b_q;
      FuncOr:  alu_res = a_q | b_q;
      FuncXor: alu_res = a_q ^ b_q;
      FuncShl: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_co  = a_q[WIDTH-1];
      end
      FuncShr: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_co  = a_q[0];
      end
    endcase
  end

  assign fin_res = is_mul ? mul_prod[WIDTH-1:0] : pend_res_q;
  assign fin_co  = is_mul ? (|mul_prod[2*WIDTH-1:WIDTH]) : pend_co_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ci_d       = ci_q;
    func_d     = func_q;
    pend_res_d = pend_res_q;
    pend_co_d  = pend_co_q;
    result_d   = result_q;
    co_d       = co_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = inputA;
          b_d     = inputB;
          ci_d    = carryIn;
          func_d  = func_in;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_mul) begin
          if (mul_fin) state_d = StDone;
        end else begin
          pend_res_d = alu_res;
          pend_co_d  = alu_co;
          state_d    = StDone;
        end
      end
      StDone: begin
        result_d = fin_res;
        co_d     = fin_co;
        zero_d   = (fin_res == '0);
        neg_d    = fin_res[WIDTH-1];
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      ci_q       <= 1'b0;
      func_q     <= FuncAdd;
      pend_res_q <= '0;
      pend_co_q  <= 1'b0;
      result_q   <= '0;
      co_q       <= 1'b0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      func_q     <= func_d;
      pend_res_q <= pend_res_d;
      pend_co_q  <= pend_co_d;
      result_q   <= result_d;
      co_q       <= co_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      done_q     <= done_d;
    end
  end

  assign result   = result_q;
  assign carryOut = co_q;
  assign zero     = zero_q;
  assign negetive = neg_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus randomized ops vs. an arithmetic model.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] inputA = 8'h00;
  logic [7:0] inputB = 8'h00;
  logic       carryIn = 1'b0;
  logic [2:0] func = 3'b000;
  logic [7:0] result;
  logic       carryOut, zero, negetive, busy, done;

  int tests = 0;
  int fails = 0;

  seq_alu #(
    .WIDTH (8),
    .MUL_EN(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inputA  (inputA),
    .inputB  (inputB),
    .carryIn (carryIn),
    .func    (func),
    .result  (result),
    .carryOut(carryOut),
    .zero    (zero),
    .negetive(negetive),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                    input logic [2:0] f, output logic [7:0] r, output logic co);
    int unsigned s;
    int unsigned p;
    s = 0;
    p = 0;
    co = 1'b0;
    case (f)
      3'd0: begin s = int'(a) + int'(b) + int'(ci); r = 8'(s % 256); co = (s >= 256); end
      3'd1: begin s = int'(a) + (255 - int'(b)) + int'(ci); r = 8'(s % 256); co = (s >= 256); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin s = int'(a) * 2; r = 8'(s % 256); co = (s >= 256); end
      3'd6: begin r = 8'(int'(a) / 2); co = a[0]; end
      default: begin p = int'(a) * int'(b); r = 8'(p % 256); co = (p >= 256); end
    endcase
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [2:0] f, input bit poke, input bit b2b);
    logic [7:0] er;
    logic       eco;
    int         cyc;
    int         lat;
    bit         got;
    ref_model(a, b, ci, f, er, eco);
    lat = (f == 3'b111) ? 9 : 2;
    @(negedge clk);
    inputA = a; inputB = b; carryIn = ci; func = f; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    // Scramble inputs: the latched operation must be unaffected.
    inputA  = 8'($urandom);
    inputB  = 8'($urandom);
    carryIn = 1'($urandom);
    func    = 3'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (poke && cyc == 3) begin
        start  = 1'b1;
        inputA = 8'hFF; inputB = 8'hFF; func = 3'b000;
      end
      if (poke && cyc == 5) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(lat));
    chk("result", 32'(result), 32'(er));
    chk("carry", 32'(carryOut), 32'(eco));
    chk("zero", 32'(zero), 32'(er == 8'h00));
    chk("neg", 32'(negetive), 32'(er[7]));
    chk("busy_at_done", 32'(busy), 32'd0);
    if (!b2b) begin
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("result_hold", 32'(result), 32'(er));
    end
  endtask

  initial begin
    bit seen;
    #12;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carryOut), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_neg", 32'(negetive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(8'h79, 8'h84, 1'b1, 3'b000, 1'b0, 1'b0);  // ADD -> FE
    run_op(8'h79, 8'h84, 1'b1, 3'b001, 1'b0, 1'b0);  // SUB -> F5, borrow
    run_op(8'h79, 8'h84, 1'b0, 3'b010, 1'b0, 1'b0);  // AND -> 00
    run_op(8'h0C, 8'h0B, 1'b0, 3'b111, 1'b0, 1'b0);  // MUL -> 84
    run_op(8'h10, 8'h10, 1'b0, 3'b111, 1'b0, 1'b0);  // MUL -> 00, co 1
    run_op(8'h0C, 8'h0B, 1'b0, 3'b111, 1'b1, 1'b0);  // MUL with start poked mid-op
    run_op(8'h81, 8'h00, 1'b0, 3'b101, 1'b0, 1'b0);  // SHL
    run_op(8'h3C, 8'h0F, 1'b1, 3'b011, 1'b0, 1'b1);  // OR, then back-to-back XOR
    run_op(8'hA5, 8'h5A, 1'b0, 3'b100, 1'b0, 1'b1);
    run_op(8'h81, 8'h00, 1'b0, 3'b110, 1'b0, 1'b0);  // SHR -> 40, co 1

    // Reset in the middle of a multiply.
    @(negedge clk);
    inputA = 8'h0F; inputB = 8'h0F; func = 3'b111; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_carry", 32'(carryOut), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    chk("midrst_neg", 32'(negetive), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    chk("result_after_rst", 32'(result), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 1'b0,
             1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
